// File: rtl/fp_pkg.sv
// Shared single-precision constants, payload layout and converter state encoding.
// Also used by the iterative adder.
package fp_pkg;

  localparam int unsigned FP_BIAS      = 127;
  localparam int unsigned I2F_EXP_BASE = 158;
  localparam int unsigned EXP_W        = 8;
  localparam int unsigned FRAC_W       = 23;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned LZ_W         = 5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } conv_state_e;

endpackage

// File: rtl/fp_round_pack.sv
// Packs a sign, leading-zero count and left-normalised magnitude into an IEEE-754 single.
// Macro I2F_RNE_EN selects round-to-nearest-even; otherwise the low bits are truncated.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  logic [LZ_W-1:0]   lz_i,
  input  logic [WORD_W-1:0] mag_i,
  output logic [WORD_W-1:0] word_c
);

  logic [EXP_W-1:0]  exp_c;
  logic [FRAC_W-1:0] frac_c;
  fp32_t             fp_c;
  logic              unused_bits;

  // bit 31 is the implicit leading one; low byte only matters when rounding
  assign unused_bits = ^{mag_i[WORD_W-1], mag_i[7:0]};

`ifdef I2F_RNE_EN
  logic            round_up_c;
  logic [FRAC_W:0] frac_sum_c;
`endif

  always_comb begin
    exp_c  = EXP_W'(I2F_EXP_BASE - 32'(lz_i));
    frac_c = mag_i[WORD_W-2:8];
`ifdef I2F_RNE_EN
    round_up_c = mag_i[7] & ((|mag_i[6:0]) | mag_i[8]);
    frac_sum_c = {1'b0, frac_c} + (FRAC_W+1)'(round_up_c);
    frac_c     = frac_sum_c[FRAC_W-1:0];
    if (frac_sum_c[FRAC_W]) begin
      exp_c = exp_c + EXP_W'(1);
    end
`endif
    fp_c.sign = sign_i;
    fp_c.exp  = exp_c;
    fp_c.frac = frac_c;
    // zero has no normalised form and is always positive
    if (mag_i == '0) begin
      fp_c = '0;
    end
    word_c = fp_c;
  end

endmodule

// File: rtl/int_to_fp_conv.sv
// Iterative 32-bit integer to single-precision converter, one normalising shift per clock.
// Rounding mode selected by macro I2F_RNE_EN (see fp_round_pack).
module int_to_fp_conv
  import fp_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] Y
);

  conv_state_e       state_q, state_d;
  logic [WORD_W-1:0] mag_q, mag_d;
  logic [LZ_W-1:0]   lz_q, lz_d;
  logic              sign_q, sign_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic              out_valid_q, out_valid_d;
  logic              in_sign_c;
  logic [WORD_W-1:0] in_mag_c;
  logic [WORD_W-1:0] word_c;

  assign in_sign_c = SIGNED & data_in[WORD_W-1];
  assign in_mag_c  = in_sign_c ? (~data_in + WORD_W'(1)) : data_in;

  fp_round_pack u_round_pack (
    .sign_i (sign_q),
    .lz_i   (lz_q),
    .mag_i  (mag_q),
    .word_c (word_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (in_mag_c == '0) ? PACK : NORM;
      NORM: if (mag_q[WORD_W-1]) state_d = PACK;
      PACK: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    mag_d       = mag_q;
    lz_d        = lz_q;
    sign_d      = sign_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign_c;
          mag_d  = in_mag_c;
          lz_d   = '0;
        end
      end
      NORM: begin
        if (!mag_q[WORD_W-1]) begin
          mag_d = {mag_q[WORD_W-2:0], 1'b0};
          lz_d  = lz_q + LZ_W'(1);
        end
      end
      PACK: begin
        y_d         = word_c;
        out_valid_d = 1'b1;
      end
      DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q       <= '0;
      lz_q        <= '0;
      sign_q      <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mag_q       <= mag_d;
      lz_q        <= lz_d;
      sign_q      <= sign_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    Y         = y_q;
  end

endmodule

// File: tb/tb_int_to_fp_conv.sv
// Directed bench for int_to_fp_conv; expectations follow macro I2F_RNE_EN when defined.
module tb_int_to_fp_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Y;

  logic        in_valid_u = 1'b0;
  logic        in_ready_u;
  logic        out_valid_u;
  logic        out_ready_u = 1'b0;
  logic [31:0] y_u;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  int_to_fp_conv #(.SIGNED(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y)
  );

  int_to_fp_conv #(.SIGNED(1'b0)) u_dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_u),
    .in_ready  (in_ready_u),
    .data_in   (data_in),
    .out_valid (out_valid_u),
    .out_ready (out_ready_u),
    .Y         (y_u)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept d, measure edges to out_valid, optionally stall with junk inputs, then drain.
  task automatic convert(input string tag, input logic [31:0] d, input logic [31:0] exp_y,
                         input int exp_lat, input int hold);
    int  lat;
    bit  seen;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_y"}, Y, exp_y);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      data_in  = 32'h12345678;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_hold_y"}, Y, exp_y);
      chk({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_7f, exp_tie_odd;
    int          lat;
    bit          seen;
`ifdef I2F_RNE_EN
    exp_7f      = 32'h4F000000;
    exp_tie_odd = 32'h4B800002;
`else
    exp_7f      = 32'h4EFFFFFF;
    exp_tie_odd = 32'h4B800001;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_y", Y, 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // reset during normalisation
    @(negedge clk);
    data_in  = 32'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("midnorm_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_ov", 32'(out_valid), 32'd0);
    chk("midrst_y", Y, 32'h0);
    chk("midrst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    convert("two", 32'd2, 32'h40000000, 32, 0);

    convert("one", 32'd1, 32'h3F800000, 33, 0);
    convert("zero", 32'd0, 32'h00000000, -1, 0);
    convert("neg5", 32'hFFFFFFFB, 32'hC0A00000, 31, 0);
    convert("max_pos", 32'h7FFFFFFF, exp_7f, 3, 0);
    convert("tie_even", 32'h01000001, 32'h4B800000, 9, 0);
    convert("tie_odd", 32'h01000003, exp_tie_odd, 9, 0);
    convert("min_neg", 32'h80000000, 32'hCF000000, 2, 0);
    convert("bp", 32'hFFFFFFFB, 32'hC0A00000, 31, 5);

    // junk offered during the stall must not have been taken
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(out_valid), 32'd0);
    chk("bp_idle", 32'(in_ready), 32'd1);

    // unsigned instance on the same boundary input
    chk("u_rdy", 32'(in_ready_u), 32'd1);
    @(negedge clk);
    data_in    = 32'h80000000;
    in_valid_u = 1'b1;
    @(posedge clk);
    #1;
    in_valid_u = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid_u) seen = 1'b1;
    end
    chk("u_seen", 32'(seen), 32'd1);
    chk("u_lat", 32'(lat), 32'd2);
    chk("u_y", y_u, 32'h4F000000);
    @(negedge clk);
    out_ready_u = 1'b1;
    @(posedge clk);
    #1;
    out_ready_u = 1'b0;
    chk("u_drain", 32'(out_valid_u), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
